wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage of the rv32i pipeline, and the writer side of the register file write port (waddr/wdata/wen).
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then extracts and sign/zero-extends the data.
- Issues a registered single-cycle write pulse to the regfile.
- Exports a pending-load indication to the hazard unit and counts retired instructions.

Parameters:
DATA_WIDTH, 32, datapath and regfile data width
RADDR_WIDTH, 5, register address width
CNT_WIDTH, 64, retired-instruction counter width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active low
in_valid  input  1  MEM stage presents an instruction
in_ready  output  1  stage can accept; equals (state==IDLE)
in_rd  input  RADDR_WIDTH  destination register
in_rd_wen  input  1  instruction writes rd
in_result  input  DATA_WIDTH  ALU/CSR/link result (non-load)
in_is_load  input  1  instruction is a load
in_funct3  input  3  load type
in_addr_lo  input  2  low bits of the load address
mem_rvalid  input  1  load data valid (single-cycle pulse)
mem_rdata  input  DATA_WIDTH  raw aligned memory word
waddr  output  RADDR_WIDTH  regfile write address
wdata  output  DATA_WIDTH  regfile write data
wen  output  1  regfile write enable, active high
load_pending  output  1  load accepted, data not yet returned
pending_rd  output  RADDR_WIDTH  rd of the outstanding load (0 when none)
load_err  output  1  one-cycle pulse: misaligned or illegal load
retire_cnt  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset: all outputs are 0, except in_ready=1 (state IDLE).
- All outputs except in_ready are registered.
- FSM states:
  - IDLE: accept when in_valid && in_ready.
    - Non-load: at the next edge, wen=(in_rd_wen && in_rd!=0), waddr=in_rd, wdata=in_result, retire_cnt+1. Throughput is 1 per cycle, so back-to-back writes are legal.
    - Load: latch rd, rd_wen, funct3, addr_lo; go to WAIT_LOAD; load_pending=1; pending_rd=in_rd. No wen is issued.
  - WAIT_LOAD: in_ready=0 and in_valid is ignored. On mem_rvalid:
    - Extract the data.
    - At the next edge: wen pulse (same rd!=0 and rd_wen rule), retire_cnt+1, load_pending=0, pending_rd=0, return to IDLE.
    - The stage can accept a new instruction in the cycle wen is high.
- Load extraction:
  - funct3 000 LB: byte at addr_lo, sign-extended.
  - funct3 100 LBU: byte at addr_lo, zero-extended.
  - funct3 001 LH: half at addr_lo[1], sign-extended.
  - funct3 101 LHU: half at addr_lo[1], zero-extended.
  - funct3 010 LW: full word.
- Load errors: funct3 011/110/111, LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
  - The error is detected at accept. The stage still waits for mem_rvalid.
  - At the write slot: wen=0, load_err=1 for one cycle, retire_cnt+1.
- wen is a single-cycle pulse. When wen=0, waddr and wdata hold their last values.
- rd=0 or in_rd_wen=0: no wen, but the instruction still retires (count increments).
- mem_rvalid while in IDLE: ignored, with no state change.
- retire_cnt wraps modulo 2^CNT_WIDTH.
- Reset asserted mid-load: the FSM returns to IDLE immediately, the pending load is dropped, no wen is issued, and the counter clears.
- Latency:
  - Non-load: wen 1 cycle after accept.
  - Load: wen 1 cycle after mem_rvalid.

Test Plan:
- Reset, then 3 back-to-back non-loads (rd=1,2,3; results 0x11,0x22,0x33) -> wen high for 3 consecutive cycles with matching waddr/wdata; retire_cnt=3; in_ready stays 1.
- LB rd=5, addr_lo=2; mem_rdata=0x0080_0000 returned 3 cycles later -> load_pending=1 and pending_rd=5 while waiting, in_ready=0; wen 1 cycle after rvalid with wdata=0xFFFF_FF80; then LBU with the same data -> 0x0000_0080.
- LH addr_lo=2, mem_rdata=0x8001_1234 -> wdata=0xFFFF_8001. LHU addr_lo=0 -> wdata=0x0000_1234.
- LW addr_lo=1 (misaligned), and funct3=011 -> no wen, load_err pulse after rvalid, retire_cnt still increments; mem_rvalid pulsed in IDLE -> no effect.
- Non-load with rd=0, result 0xDEAD -> wen stays 0 and retire_cnt increments. Then rst_n is dropped while in WAIT_LOAD -> all outputs 0 and in_ready=1, and a later mem_rvalid produces no write.

Source files
------------

// File: rtl/wb_stage.sv
// rv32i writeback stage: retires MEM-stage results, waits for and extracts load
// data, and drives a registered single-cycle write pulse into the register file.
module wb_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [RADDR_WIDTH-1:0] in_rd,
    input  logic                   in_rd_wen,
    input  logic [DATA_WIDTH-1:0]  in_result,
    input  logic                   in_is_load,
    input  logic [2:0]             in_funct3,
    input  logic [1:0]             in_addr_lo,
    input  logic                   mem_rvalid,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    output logic [RADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0]  wdata,
    output logic                   wen,
    output logic                   load_pending,
    output logic [RADDR_WIDTH-1:0] pending_rd,
    output logic                   load_err,
    output logic [CNT_WIDTH-1:0]   retire_cnt
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Illegal funct3 encodings and misaligned halfword/word accesses.
    function automatic logic f_load_illegal(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = lo[0];
            3'b010:         bad = (lo != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_extract(input logic [2:0] f3,
                                                        input logic [1:0] lo,
                                                        input logic [DATA_WIDTH-1:0] w);
        logic [7:0]            b;
        logic [15:0]           h;
        logic [DATA_WIDTH-1:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{(DATA_WIDTH-8){b[7]}}, b};
            3'b100:  r = {{(DATA_WIDTH-8){1'b0}}, b};
            3'b001:  r = {{(DATA_WIDTH-16){h[15]}}, h};
            3'b101:  r = {{(DATA_WIDTH-16){1'b0}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    state_t                 r_state, w_state_nx;
    logic [RADDR_WIDTH-1:0] r_rd;
    logic                   r_rd_wen;
    logic [2:0]             r_funct3;
    logic [1:0]             r_addr_lo;
    logic                   r_err;
    logic [RADDR_WIDTH-1:0] r_waddr, w_waddr_nx;
    logic [DATA_WIDTH-1:0]  r_wdata, w_wdata_nx;
    logic                   r_wen, w_wen_nx;
    logic                   r_load_pending, w_load_pending_nx;
    logic [RADDR_WIDTH-1:0] r_pending_rd, w_pending_rd_nx;
    logic                   r_load_err, w_load_err_nx;
    logic [CNT_WIDTH-1:0]   r_retire_cnt;
    logic                   w_retire;
    logic                   w_latch;
    logic                   w_do_write;

    always_comb begin
        w_state_nx        = r_state;
        w_waddr_nx        = r_waddr;
        w_wdata_nx        = r_wdata;
        w_wen_nx          = 1'b0;
        w_load_err_nx     = 1'b0;
        w_load_pending_nx = r_load_pending;
        w_pending_rd_nx   = r_pending_rd;
        w_retire          = 1'b0;
        w_latch           = 1'b0;
        w_do_write        = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load) begin
                        w_latch           = 1'b1;
                        w_state_nx        = WAIT_LOAD;
                        w_load_pending_nx = 1'b1;
                        w_pending_rd_nx   = in_rd;
                    end else begin
                        w_retire   = 1'b1;
                        w_do_write = in_rd_wen && (in_rd != '0);
                        w_wen_nx   = w_do_write;
                        if (w_do_write) begin
                            w_waddr_nx = in_rd;
                            w_wdata_nx = in_result;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    w_retire          = 1'b1;
                    w_state_nx        = IDLE;
                    w_load_pending_nx = 1'b0;
                    w_pending_rd_nx   = '0;
                    // A faulting load still consumes its response but never writes.
                    w_load_err_nx     = r_err;
                    w_do_write        = !r_err && r_rd_wen && (r_rd != '0);
                    w_wen_nx          = w_do_write;
                    if (w_do_write) begin
                        w_waddr_nx = r_rd;
                        w_wdata_nx = f_extract(r_funct3, r_addr_lo, mem_rdata);
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_rd           <= '0;
            r_rd_wen       <= 1'b0;
            r_funct3       <= '0;
            r_addr_lo      <= '0;
            r_err          <= 1'b0;
            r_waddr        <= '0;
            r_wdata        <= '0;
            r_wen          <= 1'b0;
            r_load_pending <= 1'b0;
            r_pending_rd   <= '0;
            r_load_err     <= 1'b0;
            r_retire_cnt   <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_waddr        <= w_waddr_nx;
            r_wdata        <= w_wdata_nx;
            r_wen          <= w_wen_nx;
            r_load_pending <= w_load_pending_nx;
            r_pending_rd   <= w_pending_rd_nx;
            r_load_err     <= w_load_err_nx;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + CNT_ONE;
            end
            if (w_latch) begin
                r_rd      <= in_rd;
                r_rd_wen  <= in_rd_wen;
                r_funct3  <= in_funct3;
                r_addr_lo <= in_addr_lo;
                r_err     <= f_load_illegal(in_funct3, in_addr_lo);
            end
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign wen          = r_wen;
    assign load_pending = r_load_pending;
    assign pending_rd   = r_pending_rd;
    assign load_err     = r_load_err;
    assign retire_cnt   = r_retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push expected write/error
// events into a queue that a negedge monitor drains whenever wen or load_err fires.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic        load_pending;
    logic [4:0]  pending_rd;
    logic        load_err;
    logic [63:0] retire_cnt;

    wb_stage #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .CNT_WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_result(in_result),
        .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .waddr(waddr), .wdata(wdata), .wen(wen),
        .load_pending(load_pending), .pending_rd(pending_rd),
        .load_err(load_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    endtask

    // Monitor: every write or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (wen === 1'b1 || load_err === 1'b1)) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: got wen=%0b load_err=%0b waddr=%0d wdata=0x%0h expected none",
                         wen, load_err, waddr, wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("evt_load_err", {63'd0, load_err}, {63'd0, e.err});
                chk("evt_wen", {63'd0, wen}, {63'd0, !e.err});
                if (!e.err) begin
                    chk("evt_waddr", {59'd0, waddr}, {59'd0, e.a});
                    chk("evt_wdata", {32'd0, wdata}, {32'd0, e.d});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; drives one non-load for one cycle and returns at posedge+1.
    task automatic issue_alu(input logic [4:0] rd, input logic rd_wen, input logic [31:0] res);
        exp_t e;
        chk("alu_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_rd_wen = rd_wen; in_result = res;
        if (rd_wen && rd != 0) begin
            e.err = 1'b0; e.a = rd; e.d = res;
            sb.push_back(e);
        end
        exp_cnt++;
        step();
        in_valid = 1'b0;
        chk("alu_retire_cnt", retire_cnt, exp_cnt);
    endtask

    task automatic issue_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] rdata, input int dly,
                              input bit is_err, input logic [31:0] exp_d);
        exp_t e;
        chk("ld_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_rd_wen = 1'b1;
        in_funct3 = f3; in_addr_lo = lo; in_result = 32'h0BAD_0BAD;
        e.err = is_err; e.a = rd; e.d = exp_d;
        sb.push_back(e);
        exp_cnt++;
        step();
        // Junk non-load held on the input while waiting must be ignored.
        in_is_load = 1'b0; in_rd = 5'd7; in_result = 32'h7777_7777;
        for (int i = 0; i < dly; i++) begin
            chk("wait_load_pending", {63'd0, load_pending}, 64'd1);
            chk("wait_pending_rd", {59'd0, pending_rd}, {59'd0, rd});
            chk("wait_in_ready", {63'd0, in_ready}, 64'd0);
            step();
        end
        in_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = rdata;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk("done_load_pending", {63'd0, load_pending}, 64'd0);
        chk("done_pending_rd", {59'd0, pending_rd}, 64'd0);
        chk("done_in_ready", {63'd0, in_ready}, 64'd1);
        chk("done_retire_cnt", retire_cnt, exp_cnt);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_wen"}, {63'd0, wen}, 64'd0);
        chk({tag, "_waddr"}, {59'd0, waddr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, wdata}, 64'd0);
        chk({tag, "_load_pending"}, {63'd0, load_pending}, 64'd0);
        chk({tag, "_pending_rd"}, {59'd0, pending_rd}, 64'd0);
        chk({tag, "_load_err"}, {63'd0, load_err}, 64'd0);
        chk({tag, "_retire_cnt"}, retire_cnt, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_result = '0;
        in_is_load = 1'b0; in_funct3 = '0; in_addr_lo = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        chk_reset_state("reset");
        rst_n = 1'b1;
        step();

        // Three back-to-back writes
        issue_alu(5'd1, 1'b1, 32'h11);
        issue_alu(5'd2, 1'b1, 32'h22);
        issue_alu(5'd3, 1'b1, 32'h33);
        step();
        chk("b2b_retire_cnt", retire_cnt, 64'd3);

        // Loads chained directly, so each next accept happens in the wen cycle
        issue_load(5'd5, 3'b000, 2'd2, 32'h0080_0000, 3, 1'b0, 32'hFFFF_FF80);
        issue_load(5'd6, 3'b100, 2'd2, 32'h0080_0000, 1, 1'b0, 32'h0000_0080);
        issue_load(5'd8, 3'b001, 2'd2, 32'h8001_1234, 2, 1'b0, 32'hFFFF_8001);
        issue_load(5'd9, 3'b101, 2'd0, 32'h8001_1234, 0, 1'b0, 32'h0000_1234);
        issue_load(5'd10, 3'b010, 2'd0, 32'hCAFE_BABE, 1, 1'b0, 32'hCAFE_BABE);
        issue_load(5'd11, 3'b010, 2'd1, 32'h1234_5678, 2, 1'b1, 32'h0);
        issue_load(5'd12, 3'b011, 2'd0, 32'h1234_5678, 1, 1'b1, 32'h0);
        issue_load(5'd13, 3'b001, 2'd3, 32'h1234_5678, 1, 1'b1, 32'h0);
        step();
        chk("err_wdata_held", {32'd0, wdata}, 64'hCAFE_BABE);
        chk("err_waddr_held", {59'd0, waddr}, 64'd10);

        // rvalid in IDLE is ignored
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("idle_rvalid_in_ready", {63'd0, in_ready}, 64'd1);
        chk("idle_rvalid_pending", {63'd0, load_pending}, 64'd0);
        chk("idle_rvalid_cnt", retire_cnt, exp_cnt);

        // rd=0 and rd_wen=0 retire without writing
        issue_alu(5'd0, 1'b1, 32'h0000_DEAD);
        issue_alu(5'd4, 1'b0, 32'h0000_BEEF);
        step();
        chk("nowrite_cnt", retire_cnt, 64'd13);
        chk("nowrite_wdata_held", {32'd0, wdata}, 64'hCAFE_BABE);

        // Reset asserted mid-load
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd20; in_rd_wen = 1'b1;
        in_funct3 = 3'b010; in_addr_lo = 2'd0;
        step();
        in_valid = 1'b0; in_is_load = 1'b0;
        chk("midload_pending", {63'd0, load_pending}, 64'd1);
        chk("midload_pending_rd", {59'd0, pending_rd}, 64'd20);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        step();
        rst_n = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 1'b0;
        step();
        chk_reset_state("post_reset");

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
